// File: rtl/sdram_port_arb.sv
// rtl/sdram_port_arb.sv - two-client round-robin arbiter in front of an SDRAM burst controller
//
// Ports:
//   sys_clk, sys_rst_n              clock, asynchronous active-low reset
//   cN_req/we/addr/len/wdata        client N (0,1) burst request; we/addr/len latched at grant
//   cN_gnt                          client N owns the port (GRANT, XFER, DONE)
//   cN_wnext                        current write word consumed, present the next one
//   cN_rdata/cN_rvalid              registered read word and its strobe
//   cN_done/cN_err                  one-cycle completion pulse; err marks a watchdog abort
//   sdram_wr_*/sdram_rd_*           burst request, start address and length per direction
//   sdram_din/sdram_dout            write data out / read data in
//   sdram_wr_ack/sdram_rd_ack       one pulse per word transferred
module sdram_port_arb #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 9,
  parameter int TMO    = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [LEN_W-1:0]  c0_len,
  input  logic [15:0]       c0_wdata,
  output logic              c0_gnt,
  output logic              c0_wnext,
  output logic [15:0]       c0_rdata,
  output logic              c0_rvalid,
  output logic              c0_done,
  output logic              c0_err,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [LEN_W-1:0]  c1_len,
  input  logic [15:0]       c1_wdata,
  output logic              c1_gnt,
  output logic              c1_wnext,
  output logic [15:0]       c1_rdata,
  output logic              c1_rvalid,
  output logic              c1_done,
  output logic              c1_err,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic [LEN_W-1:0]  sdram_wr_burst,
  output logic [LEN_W-1:0]  sdram_rd_burst,
  output logic [15:0]       sdram_din,
  input  logic [15:0]       sdram_dout,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack
);

  localparam int WD_W = (TMO < 2) ? 1 : $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;

  state_t            state, state_nx;
  logic              sel;       // client currently owning the port
  logic              last_gnt;  // client granted most recently; reset value 1 lets client 0 win first tie
  logic              pick;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  ack_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic              err_q;
  logic              rvalid_q;
  logic [15:0]       rdata_q;
  logic              ack;
  logic              last_ack;
  logic              wd_expire;

  assign pick      = (c0_req && c1_req) ? ~last_gnt : c1_req;
  // only the ack of the direction being transferred counts
  assign ack       = we_q ? sdram_wr_ack : sdram_rd_ack;
  assign last_ack  = ack && ((ack_cnt + LEN_W'(1)) == len_q);
  // wd_cnt holds the number of ack-less XFER cycles already elapsed
  assign wd_expire = !ack && (wd_cnt == WD_W'(TMO - 1));

  assign sdram_din = sel ? c1_wdata : c0_wdata;
  assign c0_rdata  = rdata_q;
  assign c1_rdata  = rdata_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    c0_gnt       = 1'b0;
    c1_gnt       = 1'b0;
    c0_wnext     = 1'b0;
    c1_wnext     = 1'b0;
    c0_done      = 1'b0;
    c1_done      = 1'b0;
    c0_err       = 1'b0;
    c1_err       = 1'b0;
    sdram_wr_req = 1'b0;
    sdram_rd_req = 1'b0;
    c0_rvalid    = rvalid_q && !sel;
    c1_rvalid    = rvalid_q && sel;
    if (state != IDLE) begin
      c0_gnt = !sel;
      c1_gnt = sel;
    end
    case (state)
      IDLE: begin
        if (c0_req || c1_req) state_nx = GRANT;
      end
      GRANT: begin
        state_nx = (len_q == '0) ? DONE : XFER;
      end
      XFER: begin
        sdram_wr_req = we_q;
        sdram_rd_req = !we_q;
        c0_wnext     = we_q && sdram_wr_ack && !sel;
        c1_wnext     = we_q && sdram_wr_ack && sel;
        if (last_ack || wd_expire) state_nx = DONE;
      end
      DONE: begin
        c0_done  = !sel;
        c1_done  = sel;
        c0_err   = err_q && !sel;
        c1_err   = err_q && sel;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel            <= 1'b0;
      last_gnt       <= 1'b1;
      we_q           <= 1'b0;
      addr_q         <= '0;
      len_q          <= '0;
      ack_cnt        <= '0;
      wd_cnt         <= '0;
      err_q          <= 1'b0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      sdram_wr_addr  <= '0;
      sdram_rd_addr  <= '0;
      sdram_wr_burst <= '0;
      sdram_rd_burst <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (c0_req || c1_req) begin
            sel      <= pick;
            last_gnt <= pick;
            we_q     <= pick ? c1_we   : c0_we;
            addr_q   <= pick ? c1_addr : c0_addr;
            len_q    <= pick ? c1_len  : c0_len;
            err_q    <= 1'b0;
          end
        end
        GRANT: begin
          ack_cnt <= '0;
          wd_cnt  <= '0;
          if (we_q) begin
            sdram_wr_addr  <= addr_q;
            sdram_wr_burst <= len_q;
          end else begin
            sdram_rd_addr  <= addr_q;
            sdram_rd_burst <= len_q;
          end
        end
        XFER: begin
          if (ack) begin
            ack_cnt <= ack_cnt + LEN_W'(1);
            wd_cnt  <= '0;
          end else if (wd_expire) begin
            err_q   <= 1'b1;
          end else begin
            wd_cnt  <= wd_cnt + WD_W'(1);
          end
          if (!we_q && sdram_rd_ack) begin
            rvalid_q <= 1'b1;
            rdata_q  <= sdram_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 Parameter ADDR_W, default 24, SDRAM word address width.
REQ-002 Parameter LEN_W, default 9, burst length counter width.
REQ-003 Parameter TMO, default 255, cycles without ack before abort.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 sys_clk  in  1  sole clock; all state on rising edge.
REQ-006 sys_rst_n  in  1  asynchronous active-low reset.
REQ-007 cN_req  in  1  per client N=0,1; transfer request, level.
REQ-008 cN_we  in  1  1=write, 0=read; sampled with grant.
REQ-009 cN_addr  in  ADDR_W  start address; sampled with grant.
REQ-010 cN_len  in  LEN_W  burst length in words; sampled with grant.
REQ-011 cN_wdata  in  16  current write word.
REQ-012 cN_gnt  out  1  client owns port, GRANT through DONE.
REQ-013 cN_wnext  out  1  current write word consumed; present next word.
REQ-014 cN_rdata / cN_rvalid  out  16 / 1  read word and its strobe.
REQ-015 cN_done / cN_err  out  1 / 1  one-cycle completion or timeout pulse.
REQ-016 sdram_wr_req, sdram_rd_req  out  1  requests to SDRAM controller.
REQ-017 sdram_wr_addr, sdram_rd_addr  out  ADDR_W  burst start address.
REQ-018 sdram_wr_burst, sdram_rd_burst  out  LEN_W  burst length.
REQ-019 sdram_din  out  16  write data; sdram_dout in 16 read data.
REQ-020 sdram_wr_ack, sdram_rd_ack  in  1  high one cycle per word transferred.

Function
REQ-021 FSM SHALL have states IDLE, GRANT, XFER, DONE.
REQ-022 IDLE: if any cN_req high, grant one client, latch we/addr/len, go GRANT next edge.
REQ-023 Arbitration SHALL be round-robin: on simultaneous requests, grant the client not granted last; after reset, client 0 wins the first tie.
REQ-024 Latched len==0: go directly to DONE, no SDRAM request issued.
REQ-025 GRANT: drive addr/burst outputs for the selected direction; go XFER; SDRAM req rises on entry to XFER (2 cycles after req sampled).
REQ-026 XFER: hold selected sdram_*_req high; count acks of the selected direction; ack of the other direction ignored.
REQ-027 Write: sdram_din = granted cN_wdata combinationally; cN_wnext = sdram_wr_ack while XFER.
REQ-028 Read: cN_rdata registered from sdram_dout, cN_rvalid high one cycle after each sdram_rd_ack.
REQ-029 When ack count reaches latched len, drop req the next cycle and go DONE; further acks ignored.
REQ-030 DONE: pulse cN_done one cycle for the granted client, release grant, return IDLE; re-arbitration in IDLE the following cycle.
REQ-031 Watchdog counter SHALL reset on each ack and on XFER entry; at TMO cycles without ack, drop req, pulse cN_err with cN_done, go IDLE.
REQ-032 Client deasserting cN_req mid-transfer SHALL NOT abort; transfer runs to completion.
REQ-033 Ack-count arithmetic SHALL be LEN_W bits, no wrap: max len 2^LEN_W-1.
REQ-034 Non-granted client outputs gnt/wnext/rvalid/done/err SHALL stay 0.

Reset
REQ-035 On sys_rst_n low, immediately: state IDLE, all req/gnt/wnext/rvalid/done/err 0, addr/burst/rdata 0, round-robin pointer favours client 0, counters 0.
REQ-036 Reset mid-transfer SHALL drop sdram_*_req asynchronously; no done pulse on release.

Verification
REQ-037 c0 write addr 0x000010 len 4, ack one cycle every other cycle -> 4 wnext pulses, sdram_wr_burst=4, wr_req falls after 4th ack, c0_done one pulse.
REQ-038 c1 read addr 0x000123 len 2, dout 0x1234 then 0x5678 -> c1_rvalid twice with rdata 0x1234, 0x5678, then c1_done.
REQ-039 c0 and c1 request same cycle, held high -> grants alternate c0, c1, c0; no overlapping gnt.
REQ-040 c0 write len 3, no ack -> after TMO=255 cycles wr_req low, c0_err and c0_done pulse together.
REQ-041 c1 len 0 -> c1_done pulse 2 cycles after grant, sdram_*_req never asserted.
REQ-042 Reset asserted during XFER after 1 of 4 acks -> all outputs 0 at once; after release, fresh request completes normally.
